sprite_line_fetcher: RTL

//  Per-scanline sprite sequencer for the VGA display path. Fetches pixel rows from the shared sprite ROM.

---
 rtl/sprite_line_fetcher.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite sequencer: clears one line-buffer bank, then fetches each visible
// sprite row from the sprite ROM and composites it into that bank for the next scanline.
module sprite_line_fetcher #(
    parameter int NSPR    = 4,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic [NSPR*10-1:0]   spr_x,
    input  logic [NSPR*10-1:0]   spr_y,
    input  logic [NSPR-1:0]      spr_en,
    output logic                 rom_rd,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [15:0]          rom_data,
    output logic                 lb_we,
    output logic                 lb_bank,
    output logic [9:0]           lb_waddr,
    output logic [15:0]          lb_wdata,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IDX_W = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NSPR - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(SPR_W - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        FETCH,
        DRAIN
    } state_t;

    state_t             state, next_state;
    logic [9:0]         tline;
    logic [9:0]         clr_cnt;
    logic [IDX_W-1:0]   spr_idx;
    logic [COL_W-1:0]   col;
    logic [2:0]         drain_cnt;
    logic [9:0]         snap_x [NSPR];
    logic [9:0]         snap_y [NSPR];
    logic [NSPR-1:0]    snap_en;
    logic               pipe_v  [ROM_LAT];
    logic [10:0]        pipe_xc [ROM_LAT];

    logic [9:0]         target_line;
    logic               trig;
    logic [9:0]         cur_x, cur_y, cur_row;
    logic               hit;
    logic [10:0]        fetch_xc;
    logic               wb_v;
    logic [10:0]        wb_xc;

    // The trigger looks one line ahead; lines 480..524 are vertical blank.
    assign target_line = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
    assign trig        = (hcount == 11'd1280) && (target_line < 10'd480);

    assign cur_x    = snap_x[spr_idx];
    assign cur_y    = snap_y[spr_idx];
    assign cur_row  = tline - cur_y;
    assign hit      = snap_en[spr_idx] && (tline >= cur_y) && (cur_row < 10'(SPR_H));
    assign fetch_xc = {1'b0, cur_x} + 11'(col);
    assign wb_v     = pipe_v[ROM_LAT-1];
    assign wb_xc    = pipe_xc[ROM_LAT-1];

    assign busy    = (state != IDLE);
    assign lb_bank = tline[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rom_rd     = 1'b0;
        rom_addr   = '0;
        lb_we      = 1'b0;
        lb_waddr   = '0;
        lb_wdata   = '0;
        case (state)
            IDLE:  ;
            CLEAR: if (clr_cnt == 10'd639) next_state = SCAN;
            SCAN: begin
                if (hit)                       next_state = FETCH;
                else if (spr_idx == IDX_LAST)  next_state = IDLE;
            end
            FETCH: if (col == COL_LAST) next_state = DRAIN;
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST)
                    next_state = (spr_idx == IDX_LAST) ? IDLE : SCAN;
            end
            default: next_state = IDLE;
        endcase
        if (trig) next_state = CLEAR;

        if (state == FETCH) begin
            rom_rd   = 1'b1;
            rom_addr = ADDR_W'(spr_idx) * ADDR_W'(SPR_W * SPR_H)
                     + ADDR_W'(cur_row) * ADDR_W'(SPR_W)
                     + ADDR_W'(col);
        end
        // Clearing and write-back never overlap: a trigger flushes the read pipeline.
        if (state == CLEAR) begin
            lb_we    = 1'b1;
            lb_waddr = clr_cnt;
        end else if (wb_v && (rom_data != 16'h0000) && (wb_xc < 11'd640)) begin
            lb_we    = 1'b1;
            lb_waddr = wb_xc[9:0];
            lb_wdata = rom_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tline     <= '0;
            clr_cnt   <= '0;
            spr_idx   <= '0;
            col       <= '0;
            drain_cnt <= '0;
            snap_en   <= '0;
            for (int i = 0; i < NSPR; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
        end else if (trig) begin
            tline     <= target_line;
            clr_cnt   <= '0;
            spr_idx   <= '0;
            col       <= '0;
            drain_cnt <= '0;
            snap_en   <= spr_en;
            for (int i = 0; i < NSPR; i++) begin
                snap_x[i] <= spr_x[10*i +: 10];
                snap_y[i] <= spr_y[10*i +: 10];
            end
        end else begin
            case (state)
                CLEAR: clr_cnt <= clr_cnt + 10'd1;
                SCAN: begin
                    col       <= '0;
                    drain_cnt <= '0;
                    if (!hit && spr_idx != IDX_LAST) spr_idx <= spr_idx + 1'b1;
                end
                FETCH: col <= col + 1'b1;
                DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (drain_cnt == DRAIN_LAST && spr_idx != IDX_LAST)
                        spr_idx <= spr_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Column position travels with each read so it lines up with the returning ROM word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_v[k]  <= 1'b0;
                pipe_xc[k] <= '0;
            end
        end else begin
            pipe_v[0]  <= (state == FETCH) && !trig;
            pipe_xc[0] <= fetch_xc;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1] && !trig;
                pipe_xc[k] <= pipe_xc[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun <= 1'b0;
        else       overrun <= trig && (state != IDLE);
    end

endmodule
